// File: rtl/bpsk_demodulator.sv
// Coherent BPSK receiver. Each incoming sample is multiplied by the local
// sine reference, and the products are summed over one symbol of
// SAMPLE_NUMBER samples. The sign of the sum is the decided bit
// (+sine -> 1, -sine or zero -> 0). Decided bits are shifted MSB-first
// into DATA_WIDTH-bit words.
//
// Pipeline: front end (acceptance / phase check) -> stage 1 (product)
// -> stage 2 (accumulate / decide) -> output stage (bit + word packing).
// A phase discontinuity or a drop of en while locked flushes every stage
// and returns the receiver to IDLE. The receiver then waits for a fresh
// phase-0 sample. DATA_WIDTH must be at least 2.
module bpsk_demodulator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 12,
  parameter int CNT_WIDTH     = $clog2(SAMPLE_NUMBER)
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    en,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sin_in,
  input  logic [CNT_WIDTH-1:0]    cnt_in,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    sync_err,
  output logic                    busy
);

  localparam int PROD_W = 2 * SAMPLE_WIDTH;
  // A full symbol of worst-case products fits in PROD_W + CNT_WIDTH bits.
  localparam int ACC_W  = PROD_W + CNT_WIDTH;
  localparam int BC_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_PH  = CNT_WIDTH'(SAMPLE_NUMBER - 1);
  localparam logic [BC_W-1:0]      LAST_BIT = BC_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  // Front-end state
  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   phase_q, phase_d;

  // Stage 1: registered product
  logic                   s1_vld_q, s1_vld_d;
  logic                   s1_last_q, s1_last_d;
  logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;

  // Stage 2: accumulator and pending decision
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                   dec_vld_q, dec_vld_d;
  logic                   dec_q, dec_d;

  // Output stage: bit and word packing
  logic [BC_W-1:0]        bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0]  sh_q, sh_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   bit_q, bit_d;
  logic                   bitv_q, bitv_d;
  logic                   datav_q, datav_d;
  logic                   serr_q, serr_d;

  // Datapath and control nets
  logic signed [SAMPLE_WIDTH-1:0] rx_s, ref_s;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        sum;
  logic                           sum_pos;
  logic accept, at_zero, in_phase, sync_hit, abort, flush, feed;

  // Offset binary -> two's complement is an MSB flip.
  assign rx_s  = {~sample_in[SAMPLE_WIDTH-1], sample_in[SAMPLE_WIDTH-2:0]};
  assign ref_s = {~sin_in[SAMPLE_WIDTH-1], sin_in[SAMPLE_WIDTH-2:0]};
  assign prod  = PROD_W'(rx_s) * PROD_W'(ref_s);
  assign sum   = acc_q + ACC_W'(s1_prod_q);
  // Strictly positive only. A zero correlation (tie) decides 0.
  assign sum_pos = !sum[ACC_W-1] && (sum != '0);

  // Front end: accept samples, track expected phase, detect loss of sync
  always_comb begin
    accept   = en & sample_valid;
    at_zero  = (cnt_in == '0);
    in_phase = (cnt_in == phase_q);
    sync_hit = (state_q == ACCUM) && accept && !in_phase;
    abort    = (state_q == ACCUM) && !en;
    flush    = sync_hit | abort;
    // A phase-0 sample always (re)starts a symbol, even on top of a sync
    // error. Otherwise only in-phase samples are taken while locked.
    feed     = accept && (at_zero || ((state_q == ACCUM) && in_phase));
    state_d  = state_q;
    phase_d  = phase_q;
    if (feed) begin
      state_d = ACCUM;
      phase_d = cnt_in + CNT_WIDTH'(1);
    end else if (flush) begin
      state_d = IDLE;
      phase_d = '0;
    end
  end

  // Stage 1: capture the product with its valid and end-of-symbol flags
  always_comb begin
    s1_vld_d  = feed;
    s1_last_d = feed && (cnt_in == LAST_PH);
    s1_prod_d = feed ? prod : s1_prod_q;
  end

  // Stage 2: accumulate; on the last product decide and restart at zero
  always_comb begin
    acc_d     = acc_q;
    dec_vld_d = 1'b0;
    dec_d     = dec_q;
    if (flush) begin
      // The in-flight symbol is dropped, including a last product
      // arriving together with the error.
      acc_d = '0;
    end else if (s1_vld_q) begin
      if (s1_last_q) begin
        dec_vld_d = 1'b1;
        dec_d     = sum_pos;
        acc_d     = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  // Output stage: present the decided bit and pack it into the word
  always_comb begin
    bit_d   = bit_q;
    bitv_d  = 1'b0;
    datav_d = 1'b0;
    data_d  = data_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    serr_d  = sync_hit;
    if (flush) begin
      // Resync discards the partial word and any decision still pending.
      sh_d   = '0;
      bcnt_d = '0;
    end else if (dec_vld_q) begin
      bit_d  = dec_q;
      bitv_d = 1'b1;
      sh_d   = {sh_q[DATA_WIDTH-2:0], dec_q};
      if (bcnt_q == LAST_BIT) begin
        bcnt_d  = '0;
        data_d  = sh_d;
        datav_d = 1'b1;
      end else begin
        bcnt_d = bcnt_q + BC_W'(1);
      end
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_prod_q <= '0;
      acc_q     <= '0;
      dec_vld_q <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      s1_prod_q <= s1_prod_d;
      acc_q     <= acc_d;
      dec_vld_q <= dec_vld_d;
      dec_q     <= dec_d;
    end
  end

  // Output and packing registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bcnt_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      bit_q   <= 1'b0;
      bitv_q  <= 1'b0;
      datav_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      bitv_q  <= bitv_d;
      datav_q <= datav_d;
      serr_q  <= serr_d;
    end
  end

  assign bit_out    = bit_q;
  assign bit_valid  = bitv_q;
  assign data_out   = data_q;
  assign data_valid = datav_q;
  assign sync_err   = serr_q;
  assign busy       = (state_q == ACCUM);

endmodule
